// File: rtl/mii_rx_nibble_driver.sv
// mii_rx_nibble_driver: buffers decoded bytes and replays them as MII receive nibbles on a divided clock
module mii_rx_nibble_driver #(
  parameter int CLK_DIV     = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int START_LEVEL = 2
) (
  input  logic       clk16x,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic       rx_packet_end_all,
  output logic       mii_rx_clk,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       mii_crs,
  output logic       overflow_flag
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, LO_NIB, HI_NIB, END} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [7:0] cur;
  logic [3:0] rxd_nxt;
  logic tick, full, empty, wr, drop, pop, end_pend, err_pend, use_err, idle_end, finish;
  logic dv_nxt, er_nxt;
  assign tick   = div_cnt == DW'(CLK_DIV - 1);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;
  assign full   = level == (AW+1)'(FIFO_DEPTH);
  assign empty  = level == '0;
  assign wr     = rx_byte_valid && !full;
  assign drop   = rx_byte_valid && full;
  assign finish = tick && (state == END || idle_end);
  // Next state and next nibble; nothing moves except on a tick
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    use_err = 1'b0;
    idle_end = 1'b0;
    rxd_nxt = mii_rxd;
    dv_nxt = mii_rx_dv;
    er_nxt = mii_rx_er;
    if (tick) begin
      case (state)
        IDLE, HI_NIB: begin
          if ((state == IDLE && (level >= (AW+1)'(START_LEVEL) || (end_pend && !empty))) ||
              (state == HI_NIB && !empty)) begin
            pop = 1'b1;
            use_err = 1'b1;
            state_nxt = LO_NIB;
            rxd_nxt = mem[rd_ptr][3:0];
            dv_nxt = 1'b1;
            er_nxt = err_pend;
          end else if (state == HI_NIB) begin
            state_nxt = END;
            rxd_nxt = 4'h0;
            dv_nxt = !end_pend;
            er_nxt = !end_pend;
          end else begin
            idle_end = end_pend;
          end
        end
        LO_NIB: begin
          use_err = 1'b1;
          state_nxt = HI_NIB;
          rxd_nxt = cur[7:4];
          er_nxt = err_pend;
        end
        default: begin
          state_nxt = IDLE;
          rxd_nxt = 4'h0;
          dv_nxt = 1'b0;
          er_nxt = 1'b0;
        end
      endcase
    end
  end
  // Byte storage has no reset; only the pointers and level define its contents
  always_ff @(posedge clk16x) begin
    if (wr) mem[wr_ptr] <= rx_byte;
  end
  // Clock divider, FIFO bookkeeping, carrier/end/error latches and registered MII outputs
  always_ff @(posedge clk16x) begin
    if (reset) begin
      div_cnt <= '0;
      mii_rx_clk <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cur <= 8'h00;
      state <= IDLE;
      mii_rxd <= 4'h0;
      mii_rx_dv <= 1'b0;
      mii_rx_er <= 1'b0;
      mii_crs <= 1'b0;
      overflow_flag <= 1'b0;
      end_pend <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      mii_rx_clk <= div_nxt >= DW'(CLK_DIV / 2);
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + (AW+1)'(wr) - (AW+1)'(pop);
      cur <= pop ? mem[rd_ptr] : cur;
      state <= state_nxt;
      mii_rxd <= rxd_nxt;
      mii_rx_dv <= dv_nxt;
      mii_rx_er <= er_nxt;
      mii_crs <= rx_byte_valid ? 1'b1 : finish ? 1'b0 : mii_crs;
      overflow_flag <= overflow_flag | drop;
      end_pend <= rx_packet_end_all ? 1'b1 : finish ? 1'b0 : end_pend;
      err_pend <= drop ? 1'b1 : use_err ? 1'b0 : err_pend;
    end
  end
endmodule

// File: tb/tb_mii_rx_nibble_driver.sv
// tb_mii_rx_nibble_driver: directed checks of nibble order, start/end/underrun/overflow handling and clock shape
module tb_mii_rx_nibble_driver;
  localparam int CLK_DIV = 64;
  logic clk16x = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic rx_byte_valid = 1'b0;
  logic rx_packet_end_all = 1'b0;
  logic mii_rx_clk, mii_rx_dv, mii_rx_er, mii_crs, overflow_flag;
  logic [3:0] mii_rxd;
  int n_cmp = 0;
  int n_bad = 0;
  mii_rx_nibble_driver #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(4), .START_LEVEL(2)) dut (
    .clk16x(clk16x), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_packet_end_all(rx_packet_end_all), .mii_rx_clk(mii_rx_clk), .mii_rxd(mii_rxd),
    .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er), .mii_crs(mii_crs), .overflow_flag(overflow_flag)
  );
  always #5 clk16x = ~clk16x;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_tick();
    logic last;
    last = mii_rx_clk;
    for (int n = 0; n < 3 * CLK_DIV; n++) begin
      @(negedge clk16x);
      if (last && !mii_rx_clk) return;
      last = mii_rx_clk;
    end
    n_cmp++;
    n_bad++;
    $error("FAIL tick_timeout: got no falling mii_rx_clk expected one within %0d cycles", 3 * CLK_DIV);
  endtask
  task automatic nib(input string tag, input logic [3:0] d, input logic dv, input logic er);
    wait_tick();
    chk({tag, "_rxd"}, {4'h0, mii_rxd}, {4'h0, d});
    chk({tag, "_dv"}, {7'h0, mii_rx_dv}, {7'h0, dv});
    chk({tag, "_er"}, {7'h0, mii_rx_er}, {7'h0, er});
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    @(negedge clk16x);
    rx_byte_valid = 1'b0;
  endtask
  task automatic send_end();
    rx_packet_end_all = 1'b1;
    @(negedge clk16x);
    rx_packet_end_all = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_clk"}, {7'h0, mii_rx_clk}, 8'h00);
    chk({tag, "_rxd"}, {4'h0, mii_rxd}, 8'h00);
    chk({tag, "_dv"}, {7'h0, mii_rx_dv}, 8'h00);
    chk({tag, "_er"}, {7'h0, mii_rx_er}, 8'h00);
    chk({tag, "_crs"}, {7'h0, mii_crs}, 8'h00);
    chk({tag, "_ovf"}, {7'h0, overflow_flag}, 8'h00);
  endtask
  logic pclk = 1'b0;
  logic [3:0] prxd = 4'h0;
  int cyc = 0;
  bit have_rise = 1'b0;
  // Clock shape and data stability across every rising mii_rx_clk
  always @(negedge clk16x) begin
    if (reset) begin
      have_rise = 1'b0;
      cyc = 0;
    end else begin
      cyc++;
      if (!pclk && mii_rx_clk) begin
        if (have_rise) begin
          n_cmp++;
          assert (cyc == CLK_DIV) else begin
            n_bad++;
            $error("FAIL period: got %0d expected %0d", cyc, CLK_DIV);
          end
        end
        n_cmp++;
        assert (mii_rxd === prxd) else begin
          n_bad++;
          $error("FAIL rxd_stable: got %0h expected %0h", mii_rxd, prxd);
        end
        have_rise = 1'b1;
        cyc = 0;
      end else if (pclk && !mii_rx_clk && have_rise) begin
        n_cmp++;
        assert (cyc == CLK_DIV / 2) else begin
          n_bad++;
          $error("FAIL high_time: got %0d expected %0d", cyc, CLK_DIV / 2);
        end
      end
    end
    pclk = mii_rx_clk;
    prxd = mii_rxd;
  end
  initial begin
    repeat (3) @(negedge clk16x);
    reset = 1'b0;
    chk_zero("reset");
    wait_tick();
    chk("pre_crs", {7'h0, mii_crs}, 8'h00);
    send(8'h55);
    chk("crs_on", {7'h0, mii_crs}, 8'h01);
    repeat (15) @(negedge clk16x);
    send(8'hD5);
    repeat (15) @(negedge clk16x);
    send(8'hA3);
    repeat (15) @(negedge clk16x);
    send_end();
    nib("p1n0", 4'h5, 1'b1, 1'b0);
    nib("p1n1", 4'h5, 1'b1, 1'b0);
    nib("p1n2", 4'h5, 1'b1, 1'b0);
    nib("p1n3", 4'hD, 1'b1, 1'b0);
    nib("p1n4", 4'h3, 1'b1, 1'b0);
    nib("p1n5", 4'hA, 1'b1, 1'b0);
    nib("p1end", 4'h0, 1'b0, 1'b0);
    chk("p1_crs_end", {7'h0, mii_crs}, 8'h01);
    wait_tick();
    chk("p1_crs_off", {7'h0, mii_crs}, 8'h00);
    wait_tick();
    send(8'h3C);
    send_end();
    nib("p2n0", 4'hC, 1'b1, 1'b0);
    nib("p2n1", 4'h3, 1'b1, 1'b0);
    nib("p2end", 4'h0, 1'b0, 1'b0);
    wait_tick();
    chk("p2_crs_off", {7'h0, mii_crs}, 8'h00);
    chk("p2_er", {7'h0, mii_rx_er}, 8'h00);
    wait_tick();
    send(8'h12);
    send(8'h34);
    send(8'h56);
    nib("p3n0", 4'h2, 1'b1, 1'b0);
    nib("p3n1", 4'h1, 1'b1, 1'b0);
    nib("p3n2", 4'h4, 1'b1, 1'b0);
    nib("p3n3", 4'h3, 1'b1, 1'b0);
    nib("p3n4", 4'h6, 1'b1, 1'b0);
    nib("p3n5", 4'h5, 1'b1, 1'b0);
    nib("p3under", 4'h0, 1'b1, 1'b1);
    chk("p3_crs_under", {7'h0, mii_crs}, 8'h01);
    nib("p3idle", 4'h0, 1'b0, 1'b0);
    chk("p3_crs_off", {7'h0, mii_crs}, 8'h00);
    wait_tick();
    for (int i = 1; i <= 6; i++) send(8'(i));
    chk("p4_ovf", {7'h0, overflow_flag}, 8'h01);
    send_end();
    nib("p4n0", 4'h1, 1'b1, 1'b1);
    nib("p4n1", 4'h0, 1'b1, 1'b0);
    nib("p4n2", 4'h2, 1'b1, 1'b0);
    nib("p4n3", 4'h0, 1'b1, 1'b0);
    nib("p4n4", 4'h3, 1'b1, 1'b0);
    nib("p4n5", 4'h0, 1'b1, 1'b0);
    nib("p4n6", 4'h4, 1'b1, 1'b0);
    nib("p4n7", 4'h0, 1'b1, 1'b0);
    nib("p4end", 4'h0, 1'b0, 1'b0);
    wait_tick();
    chk("p4_ovf_sticky", {7'h0, overflow_flag}, 8'h01);
    wait_tick();
    send(8'h9A);
    send(8'hBC);
    nib("p5n0", 4'hA, 1'b1, 1'b0);
    nib("p5n1", 4'h9, 1'b1, 1'b0);
    repeat (5) @(negedge clk16x);
    reset = 1'b1;
    @(negedge clk16x);
    reset = 1'b0;
    chk_zero("midrst");
    wait_tick();
    chk("midrst_dv", {7'h0, mii_rx_dv}, 8'h00);
    send(8'h21);
    send(8'h43);
    send_end();
    nib("p6n0", 4'h1, 1'b1, 1'b0);
    nib("p6n1", 4'h2, 1'b1, 1'b0);
    nib("p6n2", 4'h3, 1'b1, 1'b0);
    nib("p6n3", 4'h4, 1'b1, 1'b0);
    nib("p6end", 4'h0, 1'b0, 1'b0);
    wait_tick();
    chk("p6_crs_off", {7'h0, mii_crs}, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
